// File: rtl/if_id_skid_stage.sv
// Fetch/decode pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters (stall_cnt, squash_cnt) are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_stage #(
  parameter int              XLEN     = 32,
  parameter int              META_W   = 4,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013),
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h00000000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [META_W-1:0] in_meta,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_inst,
  output logic [META_W-1:0] out_meta,
  output logic [1:0]        occupancy
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       squash_cnt
`endif
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]   m_pc, m_inst, s_pc, s_inst;
  logic [META_W-1:0] m_meta, s_meta;

  logic acc, pop;
  logic load_m_in, load_m_s, load_s;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            load_m_in = 1'b1;
            state_d   = HALF;
          end
        end
        HALF: begin
          if (acc && pop) begin
            load_m_in = 1'b1;
          end else if (acc) begin
            load_s  = 1'b1;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_m_s = 1'b1;
            state_d  = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
    end
  end

  // NOTE: data registers are reset too, so the skid entry never holds stale or X contents after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc   <= '0;
      m_inst <= '0;
      m_meta <= '0;
      s_pc   <= '0;
      s_inst <= '0;
      s_meta <= '0;
    end else begin
      if (load_m_in) begin
        m_pc   <= in_pc;
        m_inst <= in_inst;
        m_meta <= in_meta;
      end else if (load_m_s) begin
        m_pc   <= s_pc;
        m_inst <= s_inst;
        m_meta <= s_meta;
      end
      if (load_s) begin
        s_pc   <= in_pc;
        s_inst <= in_inst;
        s_meta <= in_meta;
      end
    end
  end

  // An explicit bubble is driven whenever M is empty.
  assign out_valid = (state_q != EMPTY);
  assign out_pc    = out_valid ? m_pc   : RESET_PC;
  assign out_inst  = out_valid ? m_inst : NOP_INST;
  assign out_meta  = out_valid ? m_meta : '0;
  assign occupancy = state_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [1:0] n_squash;

  // Entries squashed by a flush, excluding the one decode pops in that cycle.
  assign n_squash = occupancy - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush) squash_cnt <= squash_cnt + 32'(n_squash);
    end
  end
`endif

endmodule
